lfsr: RTL and testbench

- 8-bit (width-parameterised) Fibonacci linear-feedback shift register used as a pseudo-random byte source.
- Free-runs one step per clock.
- Can be synchronously loaded with a seed at any time.
- A zero seed is substituted with a non-zero value so the register can never enter the all-zero lock-up state.

---
 rtl/lfsr.sv | 53 +++++
 tb/tb_lfsr.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lfsr.sv
// ---------------------------------------------------------------------------
// lfsr -- width-parameterised Fibonacci LFSR, pseudo-random word source.
//
// Steps one position per clock. A seed can be loaded synchronously at any
// time; a zero seed is replaced by RESET_VAL, so the all-zero lock-up state
// is unreachable.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset, q -> RESET_VAL
//   load   in   1      synchronous seed load, level-sensitive, beats shift
//   SEED   in   WIDTH  seed captured when load=1
//   q      out  WIDTH  current LFSR state, driven straight from the register
// ---------------------------------------------------------------------------
module lfsr #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0] RESET_VAL = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] SEED,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic             fb;

  always_comb begin
    // Feedback is the parity of the tapped bits; it enters at bit 0 while
    // the register shifts toward the MSB.
    fb     = ^(lfsr_q & TAPS);
    lfsr_d = {lfsr_q[WIDTH-2:0], fb};
    if (load) begin
      // A zero seed would lock the register up, so it is replaced by the
      // reset value.
      lfsr_d = (SEED == '0) ? RESET_VAL : SEED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: tb/tb_lfsr.sv
// ---------------------------------------------------------------------------
// tb_lfsr -- self-checking bench for lfsr (default 8-bit, TAPS=8'hB8).
// A reference model predicts every state from the shift/load rules; the
// directed sequences are also compared against literal vectors.
// ---------------------------------------------------------------------------
module tb_lfsr;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       load  = 1'b0;
  logic [7:0] seed  = 8'h00;
  logic [7:0] q;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_q    = 8'h01;

  lfsr #(
    .WIDTH    (8),
    .TAPS     (8'hB8),
    .RESET_VAL(8'h01)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .SEED (seed),
    .q    (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Next state from the rules: load picks seed (zero -> 1), otherwise
  // double the value modulo 256 and add the parity of the tapped bits.
  function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic ld,
                                          input logic [7:0] sd);
    int v;
    if (ld) return (sd == 8'h00) ? 8'h01 : sd;
    v = (int'(cur) * 2) % 256 + ($countones(cur & 8'hB8) % 2);
    return v[7:0];
  endfunction

  // One rising edge, then compare q against the model 1 time unit later.
  task automatic tick(input string tag);
    logic [7:0] nxt;
    nxt = rst_n ? ref_next(exp_q, load, seed) : 8'h01;
    @(posedge clk);
    #1;
    exp_q = nxt;
    check(tag, q, exp_q);
  endtask

  logic [7:0]  v_load88 [4] = '{8'h10, 8'h21, 8'h43, 8'h86};
  logic [7:0]  v_ones   [5] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
  logic [7:0]  v_zero   [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
  logic [7:0]  period_seeds [2] = '{8'h12, 8'hE4};
  int unsigned seen [256];

  initial begin
    // Reset, asserted between edges: must act without a clock edge.
    seed = 8'h88;
    #2 rst_n = 1'b0;
    #1 check("reset_async", q, 8'h01);
    for (int i = 0; i < 5; i++) tick("reset_hold");

    // Release, load 0x88 for 5 cycles, then free-run.
    rst_n = 1'b1;
    load  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("load88_model");
      check("load88_held", q, 8'h88);
    end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("run88_model");
      check("run88_vec", q, v_load88[i]);
    end

    // All-ones seed.
    seed = 8'hFF;
    load = 1'b1;
    tick("loadFF_model");
    check("loadFF", q, 8'hFF);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick("runFF_model");
      check("runFF_vec", q, v_ones[i]);
    end

    // Zero seed is substituted; never reaches zero over 300 cycles.
    seed = 8'h00;
    load = 1'b1;
    tick("load00_model");
    check("load00", q, 8'h01);
    load = 1'b0;
    begin
      int unsigned zeros;
      zeros = 0;
      for (int i = 0; i < 300; i++) begin
        tick("run00_model");
        if (i < 4) check("run00_vec", q, v_zero[i]);
        if (q == 8'h00) zeros++;
      end
      check("never_zero", zeros, 0);
    end

    // Period: every non-zero value exactly once, first return at step 255.
    for (int s = 0; s < 2; s++) begin
      int unsigned distinct;
      int unsigned first_ret;
      seed = period_seeds[s];
      load = 1'b1;
      tick("period_load");
      load = 1'b0;
      for (int v = 0; v < 256; v++) seen[v] = 0;
      first_ret = 0;
      for (int i = 1; i <= 255; i++) begin
        tick("period_model");
        seen[q]++;
        if (q == period_seeds[s] && first_ret == 0) first_ret = i;
      end
      distinct = 0;
      for (int v = 1; v < 256; v++) if (seen[v] == 1) distinct++;
      check("period_distinct", distinct, 255);
      check("period_return", first_ret, 255);
      check("period_zero_seen", seen[0], 0);
    end

    // Reset mid-run, between edges.
    tick("pre_reset_run");
    #2 rst_n = 1'b0;
    #1 check("reset_midrun", q, 8'h01);
    exp_q = 8'h01;
    // Release with load high, then reset again while load is still high.
    seed  = 8'h5A;
    load  = 1'b1;
    rst_n = 1'b1;
    tick("load5A_model");
    check("load5A", q, 8'h5A);
    #2 rst_n = 1'b0;
    #1 check("reset_midload", q, 8'h01);
    exp_q = 8'h01;
    load  = 1'b0;
    rst_n = 1'b1;
    tick("post_reset_model");
    check("post_reset_next", q, 8'h02);

    // Random phase: random loads/seeds (zero included) and rare resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        rst_n = 1'b0;
        #1 check("rand_reset_async", q, 8'h01);
        exp_q = 8'h01;
        tick("rand_reset_hold");
        rst_n = 1'b1;
      end
      load = ($urandom_range(0, 7) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick("rand_model");
      if (q == 8'h00) check("rand_nonzero", q, 8'h01);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
